ins_prefetch_unit: RTL and testbench
====================================

// Module: ins_prefetch_unit
// PURPOSE
//  Next-generation instruction fetch stage. Replaces single-word fetch with a decoupled prefetcher.
//  Requests words from instruction memory over a req/ack + rdata_valid handshake and buffers them in a DEPTH-entry FIFO.
//  Delivers instructions to the control unit, and intercepts communication instructions (start/stop/end) for the communication unit.
//  Sits between instruction memory and the control unit / communication unit. Redirects come from the memory stage.
// PARAMETERS
//  ADDR_W       32         PC / memory address width
//  INS_W        32         instruction width (>=26)
//  DEPTH        4          prefetch FIFO entries; power of 2, >=2
//  PC_STEP      1          PC increment per instruction (word addressing)
//  COMM_OPCODE  6'b111111  opcode in ins[INS_W-1 -: 6] marking a communication instruction
// PORTS
//  clock                     in   1       sole clock, rising edge
//  reset_n                   in   1       asynchronous active-low reset
//  redirect_valid_in         in   1       load redirect_pc_in as new fetch PC, flush buffer
//  redirect_pc_in            in   ADDR_W  redirect / boot PC
//  wait_for_next_in          in   1       communication unit busy; blocks delivery
//  freeze_in                 in   1       control unit stall; head held while high
//  mem_req_out               out  1       fetch request
//  mem_addr_out              out  ADDR_W  fetch address, stable while mem_req_out && !mem_ack_in
//  mem_ack_in                in   1       request accepted this cycle
//  mem_rdata_valid_in        in   1       fetch data returned this cycle
//  mem_rdata_in              in   INS_W   fetch data
//  cu_enable_out             out  1       ins_out/npc_out valid for control unit
//  ins_out                   out  INS_W   head instruction
//  npc_out                   out  ADDR_W  head PC + PC_STEP
//  communication_enable_out  out  1       one-cycle pulse: communication instruction issued
//  communication_signal_out  out  19      ins[25:7] of that instruction ([18:17] type, [16] dep, [15:0] signals)
//  halted_out                out  1       END executed; fetch stopped
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - State=IDLE; FIFO empty; no outstanding request; discard flag cleared.
//   - All outputs 0.
//  FSM states: IDLE, RUN, COMM, WAIT, HALT.
//   - Any state, redirect_valid_in=1:
//     - fetch_pc<=redirect_pc_in; FIFO cleared; state->RUN.
//     - If a request is outstanding, discard flag is set.
//     - Redirect beats every same-cycle pop/push/transition.
//   - RUN, head is COMM_OPCODE, wait_for_next_in=0 -> COMM.
//   - COMM lasts one cycle:
//     - Pulse communication_enable_out and drive communication_signal_out.
//     - Pop the head.
//     - Next state: type 2'b00 (END) -> HALT; else -> WAIT.
//   - WAIT -> RUN on the first cycle with wait_for_next_in=0. The communication unit must assert wait_for_next_in on the cycle after the pulse if it needs to stall.
//   - HALT: halted_out=1; no requests, no delivery. Left only via redirect or reset.
//  Fetch:
//   - Issue in RUN/COMM/WAIT when count + outstanding < DEPTH.
//   - At most one outstanding request, and none while discard=1.
//   - On mem_req_out && mem_ack_in: fetch_pc += PC_STEP (wraps mod 2^ADDR_W); outstanding=1.
//   - mem_rdata_valid_in arrives >=1 cycle after ack and clears outstanding.
//   - If discard=1, the data is dropped and discard is cleared; otherwise {data, addr} is pushed.
//  Delivery:
//   - cu_enable_out = RUN && !empty && head not COMM && !wait_for_next_in && !redirect_valid_in.
//   - Pop when cu_enable_out && !freeze_in.
//   - ins_out/npc_out are combinational from head; 0 when cu_enable_out=0.
//  Buffer boundaries:
//   - Full: no request issued.
//   - Empty: cu_enable_out=0.
//   - Push and pop in the same cycle is allowed at any count; count unchanged.
//   - Pointers wrap mod DEPTH.
//  Latency: mem data to cu_enable_out is 1 cycle (registered push, head visible next cycle).
//  Reset mid-transfer: outstanding cleared. A late mem_rdata_valid_in in IDLE is ignored.
// TESTING
//  T1: reset, redirect to 14, memory latency 1, 3 plain words at 14..16 -> cu_enable_out with npc_out 15,16,17 in order; no comm pulse.
//  T2: freeze_in held 5 cycles, DEPTH=4 -> mem_req_out drops after 4 buffered words; head unchanged; then resumes with no loss or duplication.
//  T3: word 0xFE000000 (start, independent) at head -> one-cycle comm pulse with signal 19'b10_0_0...0; next plain word delivered the cycle after WAIT exits.
//  T4: stop word, bench drives wait_for_next_in=1 for 4 cycles -> cu_enable_out stays 0 for those cycles, then delivery resumes at the following PC.
//  T5: redirect to 40 while a request to 20 is outstanding -> data for 20 dropped; the next delivered instruction has npc_out 41.
//  T6: END word (type 00) -> halted_out=1, mem_req_out=0 for 20 cycles; reset_n pulsed low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/ins_prefetch_unit.sv
// Decoupled instruction prefetcher: fetches into a small FIFO, feeds the
// control unit and peels off start/stop/end words for the communication unit.
module ins_prefetch_unit #(
    parameter int         ADDR_W      = 32,
    parameter int         INS_W       = 32,
    parameter int         DEPTH       = 4,
    parameter int         PC_STEP     = 1,
    parameter logic [5:0] COMM_OPCODE = 6'b111111
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              redirect_valid_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    input  logic              wait_for_next_in,
    input  logic              freeze_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_ack_in,
    input  logic              mem_rdata_valid_in,
    input  logic [INS_W-1:0]  mem_rdata_in,
    output logic              cu_enable_out,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] npc_out,
    output logic              communication_enable_out,
    output logic [18:0]       communication_signal_out,
    output logic              halted_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_COMM,
        S_WAIT,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [INS_W-1:0]  r_ins [DEPTH];
    logic [ADDR_W-1:0] r_pc  [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_outstanding;
    logic              r_discard;

    logic              w_empty;
    logic              w_head_comm;
    logic              w_fetching;
    logic              w_ack;
    logic              w_push;
    logic              w_pop;
    logic              w_cu_en;
    logic              w_comm_en;
    logic [INS_W-1:0]  w_head_ins;
    logic [ADDR_W-1:0] w_head_pc;

    assign w_head_ins  = r_ins[r_rptr];
    assign w_head_pc   = r_pc[r_rptr];
    assign w_head_comm = (w_head_ins[INS_W-1 -: 6] == COMM_OPCODE);
    assign w_empty     = (r_count == '0);
    assign w_fetching  = (r_state == S_RUN) || (r_state == S_COMM) ||
                         (r_state == S_WAIT);

    // One request in flight at most, so count < DEPTH covers count+outstanding.
    assign mem_req_out  = w_fetching && !r_outstanding && !r_discard &&
                          !redirect_valid_in && (r_count < CW'(DEPTH));
    assign mem_addr_out = r_fetch_pc;
    assign w_ack        = mem_req_out && mem_ack_in;
    assign w_push       = mem_rdata_valid_in && r_outstanding && !r_discard &&
                          !redirect_valid_in;

    assign w_cu_en   = (r_state == S_RUN) && !w_empty && !w_head_comm &&
                       !wait_for_next_in && !redirect_valid_in;
    assign w_comm_en = (r_state == S_COMM) && !redirect_valid_in;
    assign w_pop     = (w_cu_en && !freeze_in) || w_comm_en;

    assign cu_enable_out            = w_cu_en;
    assign ins_out                  = w_cu_en ? w_head_ins : '0;
    assign npc_out                  = w_cu_en ? w_head_pc + ADDR_W'(PC_STEP) : '0;
    assign communication_enable_out = w_comm_en;
    assign communication_signal_out = w_comm_en ? w_head_ins[25:7] : '0;
    assign halted_out               = (r_state == S_HALT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RUN: begin
                if (!w_empty && w_head_comm && !wait_for_next_in) begin
                    w_next = S_COMM;
                end
            end
            S_COMM: begin
                w_next = (w_head_ins[25:24] == 2'b00) ? S_HALT : S_WAIT;
            end
            S_WAIT: begin
                if (!wait_for_next_in) begin
                    w_next = S_RUN;
                end
            end
            default: begin
                w_next = r_state;
            end
        endcase
        if (redirect_valid_in) begin
            w_next = S_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_ins[r_wptr] <= mem_rdata_in;
            r_pc[r_wptr]  <= r_req_pc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= '0;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (redirect_valid_in) begin
            r_fetch_pc    <= redirect_pc_in;
            r_outstanding <= r_outstanding && !mem_rdata_valid_in;
            r_discard     <= r_outstanding && !mem_rdata_valid_in;
        end else if (w_ack) begin
            r_fetch_pc    <= r_fetch_pc + ADDR_W'(PC_STEP);
            r_req_pc      <= r_fetch_pc;
            r_outstanding <= 1'b1;
        end else if (mem_rdata_valid_in && r_outstanding) begin
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ins_prefetch_unit.sv
// Scoreboard bench for ins_prefetch_unit: a latency-configurable memory
// model feeds the DUT, a monitor pops expected deliveries and comm pulses.
module tb_ins_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        wait_for_next_in = 1'b0;
    logic        freeze_in = 1'b0;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ack_in;
    logic        mem_rdata_valid_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;
    logic        cu_enable_out;
    logic [31:0] ins_out;
    logic [31:0] npc_out;
    logic        communication_enable_out;
    logic [18:0] communication_signal_out;
    logic        halted_out;

    ins_prefetch_unit dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .redirect_valid_in        (redirect_valid_in),
        .redirect_pc_in           (redirect_pc_in),
        .wait_for_next_in         (wait_for_next_in),
        .freeze_in                (freeze_in),
        .mem_req_out              (mem_req_out),
        .mem_addr_out             (mem_addr_out),
        .mem_ack_in               (mem_ack_in),
        .mem_rdata_valid_in       (mem_rdata_valid_in),
        .mem_rdata_in             (mem_rdata_in),
        .cu_enable_out            (cu_enable_out),
        .ins_out                  (ins_out),
        .npc_out                  (npc_out),
        .communication_enable_out (communication_enable_out),
        .communication_signal_out (communication_signal_out),
        .halted_out               (halted_out)
    );

    always #5 clock = ~clock;

    assign mem_ack_in = mem_req_out;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] npc;
    } del_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [0:1023];
    del_t        exp_q[$];
    logic [18:0] comm_q[$];
    del_t        mon_e;
    logic [18:0] mon_c;

    int          mem_lat = 1;
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    int          wait_cnt = 0;

    // Memory: accepts on req (ack tied to req), answers mem_lat cycles later.
    always @(negedge clock) begin
        mem_rdata_valid_in = 1'b0;
        if (pend) begin
            if (wait_cnt == 0) begin
                mem_rdata_valid_in = 1'b1;
                mem_rdata_in = mem[pend_addr[9:0]];
                pend = 0;
            end else begin
                wait_cnt--;
            end
        end else if (mem_req_out && mem_ack_in) begin
            pend = 1;
            pend_addr = mem_addr_out;
            wait_cnt = mem_lat - 1;
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (cu_enable_out && !freeze_in) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL deliver_unexpected npc=%0d ins=%h required none",
                             npc_out, ins_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (ins_out !== mon_e.ins || npc_out !== mon_e.npc) begin
                        bad++;
                        $display("FAIL deliver npc=%0d ins=%h required npc=%0d ins=%h",
                                 npc_out, ins_out, mon_e.npc, mon_e.ins);
                    end
                end
            end
            if (communication_enable_out) begin
                total++;
                if (comm_q.size() == 0) begin
                    bad++;
                    $display("FAIL comm_unexpected sig=%h required none",
                             communication_signal_out);
                end else begin
                    mon_c = comm_q.pop_front();
                    if (communication_signal_out !== mon_c) begin
                        bad++;
                        $display("FAIL comm_sig got=%h required=%h",
                                 communication_signal_out, mon_c);
                    end
                end
            end
        end
    end

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clock); #1;
        redirect_valid_in = 1'b1;
        redirect_pc_in    = pc;
        wait_for_next_in  = 1'b0;
        @(posedge clock); #1;
        redirect_valid_in = 1'b0;
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({mem[first + i], 32'(first + i + 1)});
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({mem_req_out, cu_enable_out, communication_enable_out, halted_out} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=0000",
                     {mem_req_out, cu_enable_out, communication_enable_out, halted_out});
        end
        total++;
        if (mem_addr_out !== 32'd0 || ins_out !== 32'd0 || npc_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_buses addr=%h ins=%h npc=%h required 0",
                     mem_addr_out, ins_out, npc_out);
        end
        total++;
        if (communication_signal_out !== 19'd0) begin
            bad++;
            $display("FAIL reset_sig got=%h required=0", communication_signal_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if (mem_req_out !== 1'b0 || cu_enable_out !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet req=%b cu=%b required 0 0", mem_req_out, cu_enable_out);
        end
    endtask

    task automatic test_plain();
        int i;
        push_words(14, 3);
        do_redirect(32'd14);
        i = 0;
        do begin @(posedge clock); #1; i++; end while (exp_q.size() != 0 && i < 200);
        wait_for_next_in = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL t1_drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_freeze();
        int i;
        push_words(100, 8);
        freeze_in = 1'b1;
        do_redirect(32'd100);
        repeat (12) begin @(posedge clock); #1; end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total++;
            if (mem_req_out !== 1'b0 || cu_enable_out !== 1'b1 || npc_out !== 32'd101) begin
                bad++;
                $display("FAIL t2_full req=%b cu=%b npc=%0d required 0 1 101",
                         mem_req_out, cu_enable_out, npc_out);
            end
        end
        @(posedge clock); #1;
        freeze_in = 1'b0;
        i = 0;
        do begin @(posedge clock); #1; i++; end while (exp_q.size() != 0 && i < 200);
        wait_for_next_in = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL t2_drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_comm_start();
        int i;
        mem[200] = 32'hFE00_0000;
        comm_q.push_back(19'h40000);
        push_words(201, 1);
        do_redirect(32'd200);
        i = 0;
        do begin @(negedge clock); i++; end while (!communication_enable_out && i < 50);
        total++;
        if (!communication_enable_out) begin
            bad++;
            $display("FAIL t3_pulse got=0 required=1");
        end
        @(negedge clock);
        total++;
        if (communication_enable_out !== 1'b0 || cu_enable_out !== 1'b0) begin
            bad++;
            $display("FAIL t3_wait comm=%b cu=%b required 0 0",
                     communication_enable_out, cu_enable_out);
        end
        @(negedge clock);
        total++;
        if (cu_enable_out !== 1'b1 || npc_out !== 32'd202) begin
            bad++;
            $display("FAIL t3_next cu=%b npc=%0d required 1 202", cu_enable_out, npc_out);
        end
        i = 0;
        do begin @(posedge clock); #1; i++; end while (exp_q.size() != 0 && i < 200);
        wait_for_next_in = 1'b1;
        total++;
        if (exp_q.size() != 0 || comm_q.size() != 0) begin
            bad++;
            $display("FAIL t3_drain left=%0d/%0d required=0/0", exp_q.size(), comm_q.size());
        end
    endtask

    task automatic test_comm_stop();
        int i;
        mem[300] = 32'hFD00_0000;
        comm_q.push_back(19'h20000);
        push_words(301, 1);
        do_redirect(32'd300);
        i = 0;
        do begin @(negedge clock); i++; end while (!communication_enable_out && i < 50);
        total++;
        if (!communication_enable_out) begin
            bad++;
            $display("FAIL t4_pulse got=0 required=1");
        end
        @(posedge clock); #1;
        wait_for_next_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++;
            if (cu_enable_out !== 1'b0) begin
                bad++;
                $display("FAIL t4_blocked cycle=%0d got=%b required=0", k, cu_enable_out);
            end
        end
        @(posedge clock); #1;
        wait_for_next_in = 1'b0;
        i = 0;
        do begin @(posedge clock); #1; i++; end while (exp_q.size() != 0 && i < 200);
        wait_for_next_in = 1'b1;
        total++;
        if (exp_q.size() != 0 || comm_q.size() != 0) begin
            bad++;
            $display("FAIL t4_drain left=%0d/%0d required=0/0", exp_q.size(), comm_q.size());
        end
    endtask

    task automatic test_redirect_discard();
        int i;
        mem_lat = 3;
        push_words(40, 2);
        do_redirect(32'd20);
        i = 0;
        do begin
            @(negedge clock); i++;
        end while (!(mem_req_out && mem_ack_in && mem_addr_out == 32'd20) && i < 50);
        total++;
        if (mem_addr_out !== 32'd20) begin
            bad++;
            $display("FAIL t5_req20 addr=%0d required=20", mem_addr_out);
        end
        do_redirect(32'd40);
        i = 0;
        do begin @(posedge clock); #1; i++; end while (exp_q.size() != 0 && i < 200);
        wait_for_next_in = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL t5_drain left=%0d required=0", exp_q.size());
        end
        mem_lat = 1;
    endtask

    task automatic test_halt_reset();
        int i;
        mem[500] = 32'hFC00_0000;
        comm_q.push_back(19'h00000);
        do_redirect(32'd500);
        i = 0;
        do begin @(negedge clock); i++; end while (!halted_out && i < 50);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            total++;
            if ({halted_out, mem_req_out, cu_enable_out} !== 3'b100) begin
                bad++;
                $display("FAIL t6_halt cycle=%0d h/req/cu=%b required=100",
                         k, {halted_out, mem_req_out, cu_enable_out});
            end
        end
        total++;
        if (comm_q.size() != 0) begin
            bad++;
            $display("FAIL t6_end_pulse left=%0d required=0", comm_q.size());
        end
        mem_lat = 3;
        do_redirect(32'd600);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({mem_req_out, cu_enable_out, communication_enable_out, halted_out} !== 4'b0 ||
            mem_addr_out !== 32'd0 || npc_out !== 32'd0 || ins_out !== 32'd0) begin
            bad++;
            $display("FAIL t6_reset flags=%b addr=%h npc=%h required all 0",
                     {mem_req_out, cu_enable_out, communication_enable_out, halted_out},
                     mem_addr_out, npc_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total++;
            if ({mem_req_out, cu_enable_out, halted_out} !== 3'b000) begin
                bad++;
                $display("FAIL t6_idle cycle=%0d req/cu/h=%b required=000",
                         k, {mem_req_out, cu_enable_out, halted_out});
            end
        end
        mem_lat = 1;
        push_words(700, 2);
        do_redirect(32'd700);
        i = 0;
        do begin @(posedge clock); #1; i++; end while (exp_q.size() != 0 && i < 200);
        wait_for_next_in = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL t6_after_reset left=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0001_0000 + 32'(i);
        end
        test_reset();
        test_plain();
        test_freeze();
        test_comm_start();
        test_comm_stop();
        test_redirect_discard();
        test_halt_reset();
        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
